// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared types and constants for the SD/SPI link.
//   spi_state_e       - responder state (ABORT only reachable with
//                       SD_SPI_SLAVE_TIMEOUT_EN defined)
//   IDLE_BYTE_DEFAULT - byte shifted out when no tx data is queued
//   SPI_TIMEOUT_CNT   - frame timeout in clock50 cycles, shared with the master
//   TIMEOUT_W         - width of the frame timeout counter
package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ABORT = 2'd2
    } spi_state_e;

    localparam logic [7:0]  IDLE_BYTE_DEFAULT = 8'hFF;
    localparam int unsigned SPI_TIMEOUT_CNT   = 5000000;
    localparam int          TIMEOUT_W         = 25;

endpackage

// File: rtl/sd_spi_sync.sv
// sd_spi_sync: STAGES-flop synchronizer with single-cycle edge pulses.
//   clk, rst - sampling clock, async active-high reset
//   d        - asynchronous input
//   q        - synchronized level
//   rise     - one-cycle pulse when q goes 0->1
//   fall     - one-cycle pulse when q goes 1->0
// All flops reset to 0. For CS this means a CS held low through reset
// produces no fall pulse, so the responder waits for a fresh CS fall.
module sd_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  q & ~prev_q;
    assign fall = ~q &  prev_q;

endmodule

// File: rtl/sd_spi_slave.sv
// sd_spi_slave: SPI mode-0 responder, oversampled in the clock50 domain.
//   clock50, reset        - system clock, async active-high reset
//   SPI_CS/SCLK/MOSI      - master inputs (CS active low, SCLK <= clock50/8)
//   SPI_MISO              - registered data to master
//   rx_data/rx_valid      - last complete byte, level valid; rx_ack consumes
//   tx_data/tx_load       - write the single-entry tx buffer; tx_empty = free
//   overrun               - sticky, an unread byte was overwritten
//   frame_active          - responder is inside a CS-low frame
//   sd_timeout            - sticky frame timeout flag
// Optional: define SD_SPI_SLAVE_TIMEOUT_EN to build the frame timeout
// counter; otherwise sd_timeout is tied to 0.
module sd_spi_slave
    import sd_spi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CNT = SPI_TIMEOUT_CNT
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       SPI_CS,
    input  logic       SPI_SCLK,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic       overrun,
    output logic       frame_active,
    output logic       sd_timeout
);

    if (SYNC_STAGES < 2 || TIMEOUT_CNT < 1 || TIMEOUT_CNT >= (1 << TIMEOUT_W))
    begin : g_bad_cfg
        $error("sd_spi_slave: SYNC_STAGES must be >= 2 and TIMEOUT_CNT must fit the counter");
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic sclk_lvl_unused, cs_lvl_unused;

    sd_spi_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clock50), .rst(reset), .d(SPI_SCLK),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));

    sd_spi_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clock50), .rst(reset), .d(SPI_CS),
        .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));

    // MOSI needs only its level; same depth keeps it aligned with sclk_rise.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
    logic       rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic       tx_empty_q, tx_empty_d, miso_q, miso_d;
    logic       tx_take, rx_done, drive;

`ifdef SD_SPI_SLAVE_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CNT - 1);
    localparam logic [TIMEOUT_W-1:0] TO_SAT  = TIMEOUT_W'(TIMEOUT_CNT);
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic                 sd_timeout_q, sd_timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        miso_d     = 1'b1;
        tx_take    = 1'b0;
        rx_done    = 1'b0;
        drive      = 1'b0;
`ifdef SD_SPI_SLAVE_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        sd_timeout_d = sd_timeout_q;
`endif

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    tx_take = 1'b1;
`ifdef SD_SPI_SLAVE_TIMEOUT_EN
                    to_cnt_d     = '0;
                    sd_timeout_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    drive = 1'b1;
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        rx_done    = (bit_cnt_q == 3'd7);
                    end else if (sclk_fall) begin
                        // bit_cnt==0 on a fall only after the 8th rise of a byte
                        if (bit_cnt_q == 3'd0) tx_take = 1'b1;
                        else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
`ifdef SD_SPI_SLAVE_TIMEOUT_EN
                    if (sclk_rise || sclk_fall) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d      = ABORT;
                        sd_timeout_d = 1'b1;
                        bit_cnt_d    = '0;
                        to_cnt_d     = TO_SAT;
                        drive        = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end
            end
`ifdef SD_SPI_SLAVE_TIMEOUT_EN
            ABORT: begin
                bit_cnt_d = '0;
                if (cs_rise) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Buffer-to-shifter move happens before a same-cycle tx_load, so the
        // shifter gets the old byte and the buffer keeps the new one.
        if (tx_take) begin
            tx_shift_d = tx_empty_q ? IDLE_BYTE : tx_buf_q;
            tx_empty_d = 1'b1;
        end
        if (tx_load) begin
            tx_buf_d   = tx_data;
            tx_empty_d = 1'b0;
        end
        if (rx_done) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
        end
        // MISO follows the shifter's next value to save a cycle of latency.
        if (drive) miso_d = tx_shift_d[7];
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= IDLE_BYTE;
            tx_shift_q  <= IDLE_BYTE;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_buf_q    <= '0;
            tx_empty_q  <= 1'b1;
            miso_q      <= 1'b1;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            miso_q      <= miso_d;
        end
    end

`ifdef SD_SPI_SLAVE_TIMEOUT_EN
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            to_cnt_q     <= '0;
            sd_timeout_q <= 1'b0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            sd_timeout_q <= sd_timeout_d;
        end
    end
    assign sd_timeout = sd_timeout_q;
`else
    assign sd_timeout = 1'b0;
`endif

    assign SPI_MISO     = miso_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign overrun      = overrun_q;
    assign tx_empty     = tx_empty_q;
    // Tracks the synchronized CS low, but stays 0 for a CS still low after reset.
    assign frame_active = (state_q != IDLE);

endmodule

// File: tb/tb_sd_spi_slave.sv
// tb_sd_spi_slave: directed scenarios plus a randomized multi-frame run
// checked against a transaction-level model of the responder.
module tb_sd_spi_slave;

    localparam int SS = 2;
    localparam int TO = 100;

    logic       clock50 = 1'b0;
    logic       reset, SPI_CS, SPI_SCLK, SPI_MOSI, rx_ack, tx_load;
    logic [7:0] tx_data, rx_data;
    logic       SPI_MISO, rx_valid, tx_empty, overrun, frame_active, sd_timeout;

    int checks = 0;
    int errors = 0;

    // transaction-level model state
    logic [7:0] m_buf, m_shift, m_rx_data;
    bit         m_full, m_rx_valid, m_overrun;

    sd_spi_slave #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF), .TIMEOUT_CNT(TO)) dut (
        .clock50(clock50), .reset(reset), .SPI_CS(SPI_CS), .SPI_SCLK(SPI_SCLK),
        .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .tx_data(tx_data),
        .tx_load(tx_load), .tx_empty(tx_empty), .overrun(overrun),
        .frame_active(frame_active), .sd_timeout(sd_timeout));

    always #10 clock50 = ~clock50;

    // inputs change on negedges, away from the sampling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clock50);
    endtask

    task automatic cs_low();
        SPI_CS = 1'b0; tick(8);
    endtask

    task automatic cs_high();
        SPI_CS = 1'b1; tick(8);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d; tx_load = 1'b1; tick(1); tx_load = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1; tick(1); rx_ack = 1'b0; tick(1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(4); SPI_SCLK = 1'b1; tick(4); SPI_SCLK = 0;
        end
        tick(4);
    endtask

    // Mode-0 master byte, half period 4 clocks. ack_last pulses rx_ack on
    // the very cycle the responder acts on the 8th rising edge.
    task automatic xfer(input logic [7:0] mo, input bit ack_last, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            SPI_MOSI = mo[i];
            tick(4);
            SPI_SCLK = 1'b1;
            mi[i] = SPI_MISO;
            if (ack_last && i == 0) begin
                tick(2); rx_ack = 1'b1; tick(1); rx_ack = 1'b0; tick(1);
            end else begin
                tick(4);
            end
            SPI_SCLK = 1'b0;
        end
        tick(4);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(3); reset = 1'b0; tick(4);
    endtask

    task automatic test_reset();
        SPI_CS = 1'b1; SPI_SCLK = 1'b0; SPI_MOSI = 1'b0;
        rx_ack = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        reset = 1'b1; tick(3);
        checks++; if (SPI_MISO !== 1'b1) begin errors++; $display("FAIL reset_miso got=%b exp=1", SPI_MISO); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty got=%b exp=1", tx_empty); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b exp=0", frame_active); end
        checks++; if (sd_timeout !== 1'b0) begin errors++; $display("FAIL reset_sd_timeout got=%b exp=0", sd_timeout); end
        reset = 1'b0; tick(4);
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        load_tx(8'hA5);
        checks++; if (tx_empty !== 1'b0) begin errors++; $display("FAIL basic_loaded got=%b exp=0", tx_empty); end
        cs_low();
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL basic_frame_on got=%b exp=1", frame_active); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL basic_taken got=%b exp=1", tx_empty); end
        xfer(8'h3C, 1'b0, mi);
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso got=%h exp=a5", mi); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data got=%h exp=3c", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_rx_valid got=%b exp=1", rx_valid); end
        cs_high();
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL basic_frame_off got=%b exp=0", frame_active); end
        ack();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got=%b exp=0", rx_valid); end
    endtask

    task automatic test_idle_fill();
        logic [7:0] mi;
        cs_low();
        xfer(8'h55, 1'b0, mi);
        checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL idle_byte0 got=%h exp=ff", mi); end
        ack();
        xfer(8'hAA, 1'b0, mi);
        checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL idle_byte1 got=%h exp=ff", mi); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL idle_tx_empty got=%b exp=1", tx_empty); end
        checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL idle_rx_data got=%h exp=aa", rx_data); end
        cs_high(); ack();
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        cs_low();
        xfer(8'h11, 1'b0, mi);
        xfer(8'h22, 1'b0, mi);
        cs_high();
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_rx_data got=%h exp=22", rx_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        ack();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid got=%b exp=0", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_partial();
        logic [7:0] mi;
        cs_low(); pulses(5); cs_high();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL partial_dropped got=%b exp=0", rx_valid); end
        cs_low();
        xfer(8'h81, 1'b0, mi);
        cs_high();
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL partial_next got=%h exp=81", rx_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL partial_overrun got=%b exp=0", overrun); end
        ack();
    endtask

    task automatic test_ack_collide();
        logic [7:0] mi;
        cs_low();
        xfer(8'h12, 1'b0, mi);
        xfer(8'h34, 1'b1, mi);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL collide_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL collide_data got=%h exp=34", rx_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL collide_overrun got=%b exp=0", overrun); end
        cs_high(); ack();
    endtask

    // overwrite while full, then a tx_load on the exact CS-fall take cycle
    task automatic test_tx_buffer();
        logic [7:0] mi;
        load_tx(8'h01);
        load_tx(8'hC3);
        SPI_CS = 1'b0; tick(2);
        load_tx(8'h77);
        tick(5);
        checks++; if (tx_empty !== 1'b0) begin errors++; $display("FAIL txbuf_kept_new got=%b exp=0", tx_empty); end
        xfer(8'h00, 1'b0, mi);
        checks++; if (mi !== 8'hC3) begin errors++; $display("FAIL txbuf_old_byte got=%h exp=c3", mi); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL txbuf_consumed got=%b exp=1", tx_empty); end
        xfer(8'h00, 1'b0, mi);
        checks++; if (mi !== 8'h77) begin errors++; $display("FAIL txbuf_new_byte got=%h exp=77", mi); end
        cs_high(); ack();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        load_tx(8'h9E);
        cs_low(); pulses(3);
        reset = 1'b1; tick(2); reset = 1'b0; tick(4);
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL midrst_frame got=%b exp=0", frame_active); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL midrst_tx_empty got=%b exp=1", tx_empty); end
        xfer(8'h5A, 1'b0, mi);
        checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL midrst_miso got=%h exp=ff", mi); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_ignored got=%b exp=0", rx_valid); end
        cs_high(); cs_low();
        xfer(8'hC4, 1'b0, mi);
        cs_high();
        checks++; if (rx_data !== 8'hC4) begin errors++; $display("FAIL midrst_rearm got=%h exp=c4", rx_data); end
        ack();
    endtask

`ifdef SD_SPI_SLAVE_TIMEOUT_EN
    task automatic test_timeout();
        cs_low();
        SPI_SCLK = 1'b1; tick(4); SPI_SCLK = 1'b0; tick(4); SPI_SCLK = 1'b1;
        tick(50);
        checks++; if (sd_timeout !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", sd_timeout); end
        tick(60);
        checks++; if (sd_timeout !== 1'b1) begin errors++; $display("FAIL to_fired got=%b exp=1", sd_timeout); end
        checks++; if (SPI_MISO !== 1'b1) begin errors++; $display("FAIL to_miso got=%b exp=1", SPI_MISO); end
        SPI_SCLK = 1'b0;
        pulses(8);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL to_ignored got=%b exp=0", rx_valid); end
        cs_high();
        checks++; if (sd_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", sd_timeout); end
        cs_low();
        checks++; if (sd_timeout !== 1'b0) begin errors++; $display("FAIL to_cleared got=%b exp=0", sd_timeout); end
        cs_high();
    endtask
`else
    task automatic test_timeout();
        cs_low(); tick(200);
        checks++; if (sd_timeout !== 1'b0) begin errors++; $display("FAIL to_tied got=%b exp=0", sd_timeout); end
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL to_frame got=%b exp=1", frame_active); end
        cs_high();
    endtask
`endif

    task automatic test_random();
        logic [7:0] mi, mo, exp_mi, d;
        bit         al;
        int         nb;
        do_reset();
        m_full = 1'b0; m_buf = 8'h00; m_rx_valid = 1'b0; m_overrun = 1'b0; m_rx_data = 8'h00;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom); load_tx(d); m_buf = d; m_full = 1'b1;
            end
            cs_low();
            m_shift = m_full ? m_buf : 8'hFF; m_full = 1'b0;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                mo = 8'($urandom);
                al = ($urandom_range(0, 3) == 0);
                xfer(mo, al, mi);
                exp_mi = m_shift;
                if (al) m_overrun = 1'b0;
                else if (m_rx_valid) m_overrun = 1'b1;
                m_rx_data = mo; m_rx_valid = 1'b1;
                m_shift = m_full ? m_buf : 8'hFF; m_full = 1'b0;
                checks++; if (mi !== exp_mi) begin errors++; $display("FAIL rnd_miso f%0d b%0d got=%h exp=%h", f, b, mi, exp_mi); end
                checks++; if (rx_data !== m_rx_data) begin errors++; $display("FAIL rnd_rx_data f%0d b%0d got=%h exp=%h", f, b, rx_data, m_rx_data); end
                checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL rnd_overrun f%0d b%0d got=%b exp=%b", f, b, overrun, m_overrun); end
                checks++; if (tx_empty !== !m_full) begin errors++; $display("FAIL rnd_tx_empty f%0d b%0d got=%b exp=%b", f, b, tx_empty, !m_full); end
                if ($urandom_range(0, 1) == 1) begin
                    ack(); m_rx_valid = 1'b0; m_overrun = 1'b0;
                end
                checks++; if (rx_valid !== m_rx_valid) begin errors++; $display("FAIL rnd_rx_valid f%0d b%0d got=%b exp=%b", f, b, rx_valid, m_rx_valid); end
                if ($urandom_range(0, 2) == 0) begin
                    d = 8'($urandom); load_tx(d); m_buf = d; m_full = 1'b1;
                end
            end
            cs_high();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_fill();
        test_overrun();
        test_partial();
        test_ack_collide();
        test_tx_buffer();
        test_reset_mid_frame();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
